// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan chain load / capture / unload sequencer
// Optional capture+unload phase built when SCAN_CTRL_CAPTURE_EN is defined.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 capture_en,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] unload_data,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO
);
  localparam int CNT_W = $clog2(CHAIN_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

`ifdef SCAN_CTRL_CAPTURE_EN
  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, DONE} state_t;
  logic cap_q;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  logic unused_capture_en;
  assign unused_capture_en = capture_en;
`endif

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] load_sr;
  logic [CHAIN_LEN-1:0] unload_sr;
  logic                 last;

  assign last = (cnt == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      load_sr     <= '0;
      unload_sr   <= '0;
      unload_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      SE          <= 1'b0;
      SI          <= 1'b0;
`ifdef SCAN_CTRL_CAPTURE_EN
      cap_q       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // SI is registered, so the MSB is presented on the accepting edge
            SI      <= load_data[CHAIN_LEN-1];
            load_sr <= {load_data[CHAIN_LEN-2:0], 1'b0};
            SE      <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
            state   <= SHIFT;
`ifdef SCAN_CTRL_CAPTURE_EN
            cap_q   <= capture_en;
`endif
          end
        end
        SHIFT: begin
          unload_sr <= {unload_sr[CHAIN_LEN-2:0], SO};
          load_sr   <= load_sr << 1;
          SI        <= load_sr[CHAIN_LEN-1];
          cnt       <= cnt + 1'b1;
          if (last) begin
            cnt <= '0;
            SI  <= 1'b0;
            SE  <= 1'b0;
`ifdef SCAN_CTRL_CAPTURE_EN
            if (cap_q) begin
              state <= CAPTURE;
            end else begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              unload_data <= {unload_sr[CHAIN_LEN-2:0], SO};
            end
`else
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            unload_data <= {unload_sr[CHAIN_LEN-2:0], SO};
`endif
          end
        end
`ifdef SCAN_CTRL_CAPTURE_EN
        CAPTURE: begin
          SE    <= 1'b1;
          SI    <= 1'b0;
          cnt   <= '0;
          state <= UNLOAD;
        end
        UNLOAD: begin
          unload_sr <= {unload_sr[CHAIN_LEN-2:0], SO};
          cnt       <= cnt + 1'b1;
          if (last) begin
            cnt         <= '0;
            SE          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            unload_data <= {unload_sr[CHAIN_LEN-2:0], SO};
            state       <= DONE;
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
